// File: rtl/if_icache.sv
// Direct-mapped instruction cache with a fetch window that may span up to the line end.
// Lookup is combinational from pc_i; misses refill a whole line over a beat-serial memory port.
module if_icache #(
   parameter int PC_BITS       = 32,
   parameter int FETCH_WIDTH   = 64,
   parameter int LINE_BITS     = 256,
   parameter int SETS          = 64,
   parameter int MEM_BEAT_BITS = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [PC_BITS-1:0]       pc_i,
   input  logic                     invalidate_i,
   output logic                     hit_o,
   output logic                     miss_o,
   output logic                     partial_access_o,
   output logic [1:0]               partial_type_o,
   output logic [FETCH_WIDTH-1:0]   fetched_data_o,
   output logic                     mem_req_valid_o,
   input  logic                     mem_req_ready_i,
   output logic [PC_BITS-1:0]       mem_req_addr_o,
   input  logic                     mem_resp_valid_i,
   input  logic [MEM_BEAT_BITS-1:0] mem_resp_data_i,
   output logic [31:0]              miss_count_o
);

   localparam int OFF_BITS    = $clog2(LINE_BITS / 8);
   localparam int IDX_BITS    = $clog2(SETS);
   localparam int TAG_BITS    = PC_BITS - OFF_BITS - IDX_BITS;
   localparam int HW_BITS     = OFF_BITS - 1;
   localparam int HW_PER_LINE = LINE_BITS / 16;
   localparam int FETCH_HW    = FETCH_WIDTH / 16;
   localparam int BEATS       = LINE_BITS / MEM_BEAT_BITS;
   localparam int CNT_BITS    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [HW_BITS-1:0]  PARTIAL_HW = HW_BITS'(HW_PER_LINE - FETCH_HW + 1);
   localparam logic [CNT_BITS-1:0] LAST_BEAT  = CNT_BITS'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, REQ, REFILL, FILL} state_t;

   state_t state, next_state;

   logic [LINE_BITS-1:0] data_array [SETS];
   logic [TAG_BITS-1:0]  tag_array  [SETS];
   logic [SETS-1:0]      valid;

   logic [BEATS-1:0][MEM_BEAT_BITS-1:0] line_buf;
   logic [CNT_BITS-1:0]  cnt;
   logic [PC_BITS-1:0]   req_addr;
   logic [31:0]          miss_count;
   logic                 drop;

   logic [HW_BITS-1:0]   hw;
   logic [IDX_BITS-1:0]  index;
   logic [TAG_BITS-1:0]  tag;
   logic [IDX_BITS-1:0]  req_index;
   logic [TAG_BITS-1:0]  req_tag;
   logic [LINE_BITS-1:0] line_rd;
   logic [LINE_BITS-1:0] line_shifted;
   logic                 hit;
   logic                 unused_pc0;

   assign unused_pc0 = pc_i[0];
   assign hw         = pc_i[OFF_BITS-1:1];
   assign index      = pc_i[OFF_BITS +: IDX_BITS];
   assign tag        = pc_i[PC_BITS-1 -: TAG_BITS];
   assign req_index  = req_addr[OFF_BITS +: IDX_BITS];
   assign req_tag    = req_addr[PC_BITS-1 -: TAG_BITS];

   assign hit     = (state == IDLE) && valid[index] && (tag_array[index] == tag);
   assign hit_o   = hit;
   assign miss_o  = ~hit;

   // Logical shift zero-fills halfwords that fall beyond the line end.
   assign line_rd        = data_array[index];
   assign line_shifted   = line_rd >> {hw, 4'b0000};
   assign fetched_data_o = line_shifted[FETCH_WIDTH-1:0];

   // Halfwords left in the line = HW_PER_LINE - hw, which for a partial window is (-hw) mod 4.
   assign partial_access_o = hit && (hw >= PARTIAL_HW);
   assign partial_type_o   = partial_access_o ? (2'b00 - hw[1:0]) : 2'b00;

   assign mem_req_valid_o = (state == REQ);
   assign mem_req_addr_o  = req_addr;
   assign miss_count_o    = miss_count;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!hit) next_state = REQ;
         REQ:     if (mem_req_ready_i) next_state = REFILL;
         REFILL:  if (mem_resp_valid_i && (cnt == LAST_BEAT)) next_state = FILL;
         FILL:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         valid      <= '0;
         drop       <= 1'b0;
         cnt        <= '0;
         req_addr   <= '0;
         miss_count <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && !hit) begin
            req_addr   <= {tag, index, OFF_BITS'(0)};
            miss_count <= miss_count + 32'd1;
         end
         if (state == REQ && mem_req_ready_i) cnt <= '0;
         if (state == REFILL && mem_resp_valid_i) cnt <= cnt + 1'b1;
         if (state == FILL) drop <= 1'b0;
         else if (invalidate_i && state != IDLE) drop <= 1'b1;
         // Invalidate takes priority over a fill landing in the same cycle.
         if (invalidate_i) valid <= '0;
         else if (state == FILL) valid[req_index] <= ~drop;
      end
   end

   always_ff @(posedge clk) begin
      if (state == REFILL && mem_resp_valid_i) line_buf[cnt] <= mem_resp_data_i;
      if (state == FILL) begin
         data_array[req_index] <= line_buf;
         tag_array[req_index]  <= req_tag;
      end
   end

endmodule
